// File: rtl/led_chaser_pkg.sv
// led_chaser_pkg: shared LED width, reset pattern, direction type and one-hot helper
package led_chaser_pkg;
    localparam int LED_W = 8;
    localparam logic [LED_W-1:0] LED_RESET = 8'b1000_0000;
    typedef enum logic {DIR_DOWN, DIR_UP} dir_e;
    function automatic logic one_hot(input logic [LED_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction
endpackage

// File: rtl/led_chaser_tick_gen.sv
// tick_gen: W-bit free-running prescaler (CLK, RST async high) with tick high for one cycle at all-ones
module tick_gen #(
    parameter int W = 22
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);
    logic [W-1:0] count;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) count <= '0;
        else     count <= count + W'(1);
    end
    assign tick = &count;
endmodule

// File: rtl/led_chaser.sv
// led_chaser: one-hot 8-LED chaser stepping every 2**CLK_DIV clocks; CLK/RST in, LEDS out; LED_CHASER_BOUNCE_EN selects ping-pong motion
module led_chaser
    import led_chaser_pkg::*;
#(
    parameter int CLK_DIV = 22
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [LED_W-1:0] LEDS
);
    logic tick;
    logic [LED_W-1:0] leds_next;
    tick_gen #(.W(CLK_DIV)) u_tick (.CLK(CLK), .RST(RST), .tick(tick));
`ifdef LED_CHASER_BOUNCE_EN
    dir_e dir, dir_next;
    logic at_end;
    always_comb begin
        at_end    = (dir == DIR_DOWN) ? LEDS[0] : LEDS[LED_W-1];
        dir_next  = !one_hot(LEDS) ? DIR_DOWN :
                    at_end ? ((dir == DIR_DOWN) ? DIR_UP : DIR_DOWN) : dir;
        // moving in the post-turn direction makes the end LED bounce without lingering
        leds_next = !one_hot(LEDS) ? LED_RESET :
                    (dir_next == DIR_DOWN) ? LEDS >> 1 : LEDS << 1;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LEDS <= LED_RESET;
            dir  <= DIR_DOWN;
        end else if (tick) begin
            LEDS <= leds_next;
            dir  <= dir_next;
        end
    end
`else
    assign leds_next = one_hot(LEDS) ? {LEDS[0], LEDS[LED_W-1:1]} : LED_RESET;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       LEDS <= LED_RESET;
        else if (tick) LEDS <= leds_next;
    end
`endif
endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: directed self-checking bench for led_chaser at CLK_DIV=6
module tb_led_chaser;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] leds;
    int checks = 0;
    int errors = 0;

    led_chaser #(.CLK_DIV(6)) dut (.CLK(clk), .RST(rst), .LEDS(leds));

    always #5 clk = ~clk;

    function automatic logic is_one_hot(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n == 1;
    endfunction

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clocks(3);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (leds !== 8'h80) begin
            errors++;
            $display("FAIL reset_held: leds=%h expected=%h", leds, 8'h80);
        end
        clocks(3);
        checks++;
        if (leds !== 8'h80) begin
            errors++;
            $display("FAIL reset_clocked: leds=%h expected=%h", leds, 8'h80);
        end
        @(negedge clk);
        rst = 1'b0;
        clocks(16);
        checks++;
        if (leds !== 8'h80) begin
            errors++;
            $display("FAIL reset_16clk: leds=%h expected=%h", leds, 8'h80);
        end
    endtask

    task automatic test_first_step();
        do_reset();
        clocks(63);
        checks++;
        if (leds !== 8'h80) begin
            errors++;
            $display("FAIL first_step_63: leds=%h expected=%h", leds, 8'h80);
        end
        clocks(1);
        checks++;
        if (leds !== 8'h40) begin
            errors++;
            $display("FAIL first_step_64: leds=%h expected=%h", leds, 8'h40);
        end
    endtask

    task automatic test_sequence();
`ifdef LED_CHASER_BOUNCE_EN
        logic [7:0] exp_tab [16] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                     8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
`else
        logic [7:0] exp_tab [16] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                     8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
`endif
        logic [7:0] expected;
        do_reset();
        for (int c = 1; c <= 15 * 64; c++) begin
            clocks(1);
            expected = exp_tab[c / 64];
            checks++;
            if (!is_one_hot(leds)) begin
                errors++;
                $display("FAIL one_hot clk=%0d: leds=%h not one-hot", c, leds);
            end
            checks++;
            if (leds !== expected) begin
                errors++;
                $display("FAIL sequence clk=%0d: leds=%h expected=%h", c, leds, expected);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        clocks(3 * 64 + 20);
        checks++;
        if (leds !== 8'h10) begin
            errors++;
            $display("FAIL async_pre: leds=%h expected=%h", leds, 8'h10);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (leds !== 8'h80) begin
            errors++;
            $display("FAIL async_immediate: leds=%h expected=%h", leds, 8'h80);
        end
        clocks(2);
        @(negedge clk);
        rst = 1'b0;
        clocks(63);
        checks++;
        if (leds !== 8'h80) begin
            errors++;
            $display("FAIL async_restart_63: leds=%h expected=%h", leds, 8'h80);
        end
        clocks(1);
        checks++;
        if (leds !== 8'h40) begin
            errors++;
            $display("FAIL async_restart_64: leds=%h expected=%h", leds, 8'h40);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clocks(100);
        do_reset();
        clocks(63);
        checks++;
        if (leds !== 8'h80) begin
            errors++;
            $display("FAIL b2b_63: leds=%h expected=%h", leds, 8'h80);
        end
        clocks(65);
        checks++;
        if (leds !== 8'h20) begin
            errors++;
            $display("FAIL b2b_128: leds=%h expected=%h", leds, 8'h20);
        end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_sequence();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
